// File: rtl/operand_regfile.sv
// operand_regfile: ALU-side register file with r0 hardwired to zero,
// write-through bypass on both read ports, and latched Z/N flags.
module operand_regfile #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] out_A,
    output logic [DATA_W-1:0] out_B,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              flag_we,
    input  logic              Z_in,
    input  logic              N_in,
    output logic              Z_q,
    output logic              N_q
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_z;
    logic              r_n;

    logic              w_ld_hit;
    logic              w_wr_hit;

    // Commit qualifiers: r0 is never written, and a load to the same address shadows the writeback.
    assign w_ld_hit = ld_en && (ld_addr != '0);
    assign w_wr_hit = wr_en && (wr_addr != '0) && !(ld_en && (ld_addr == wr_addr));

    // Register array: async clear, load and writeback may commit together to different addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_ld_hit) begin
                r_regs[ld_addr] <= ld_data;
            end
            if (w_wr_hit) begin
                r_regs[wr_addr] <= wr_data;
            end
        end
    end

    // Flag latch, independent of the data write path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_z <= 1'b0;
            r_n <= 1'b0;
        end else if (flag_we) begin
            r_z <= Z_in;
            r_n <= N_in;
        end
    end

    assign Z_q = r_z;
    assign N_q = r_n;

    // Read port A: reset and r0 force zero, then load bypass, then writeback bypass, then storage.
    always_comb begin
        out_A = '0;
        if (!rst || (rd_addr_a == '0)) begin
            out_A = '0;
        end else if (ld_en && (ld_addr == rd_addr_a)) begin
            out_A = ld_data;
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            out_A = wr_data;
        end else begin
            out_A = r_regs[rd_addr_a];
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        out_B = '0;
        if (!rst || (rd_addr_b == '0)) begin
            out_B = '0;
        end else if (ld_en && (ld_addr == rd_addr_b)) begin
            out_B = ld_data;
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            out_B = wr_data;
        end else begin
            out_B = r_regs[rd_addr_b];
        end
    end

endmodule

// File: tb/tb_operand_regfile.sv
// Bench for operand_regfile: next-state model plus directed literal checks.
module tb_operand_regfile;

    logic       clk;
    logic       rst;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [7:0] out_A;
    logic [7:0] out_B;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic       flag_we;
    logic       Z_in;
    logic       N_in;
    logic       Z_q;
    logic       N_q;

    int n_checks;
    int n_fail;

    operand_regfile #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .out_A(out_A), .out_B(out_B),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .flag_we(flag_we), .Z_in(Z_in), .N_in(N_in),
        .Z_q(Z_q), .N_q(N_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: plain array of register contents and two flag bits.
    logic [7:0] m_regs [8];
    logic       m_z;
    logic       m_n;

    // Contents the array will hold after the coming edge; r0 stays 0, load applied last so it wins.
    function automatic void next_state(output logic [7:0] nxt [8]);
        for (int i = 0; i < 8; i++) nxt[i] = m_regs[i];
        if (wr_en && wr_addr != 3'd0) nxt[wr_addr] = wr_data;
        if (ld_en && ld_addr != 3'd0) nxt[ld_addr] = ld_data;
    endfunction

    // A read port shows the post-edge value of its register, or zero while in reset.
    function automatic logic [7:0] exp_read(input logic [2:0] a);
        logic [7:0] nxt [8];
        next_state(nxt);
        if (!rst) return 8'h00;
        return nxt[a];
    endfunction

    // Model update on the same events as the hardware.
    always @(posedge clk or negedge rst) begin
        logic [7:0] nxt [8];
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            m_z = 1'b0;
            m_n = 1'b0;
        end else begin
            next_state(nxt);
            for (int i = 0; i < 8; i++) m_regs[i] = nxt[i];
            if (flag_we) begin
                m_z = Z_in;
                m_n = N_in;
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        check8("model_out_A", out_A, exp_read(rd_addr_a));
        check8("model_out_B", out_B, exp_read(rd_addr_b));
        check1("model_Z_q", Z_q, m_z);
        check1("model_N_q", N_q, m_n);
    end

    task automatic idle();
        wr_en = 1'b0; ld_en = 1'b0; flag_we = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ld(input logic [2:0] a, input logic [7:0] d);
        idle();
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
        ld_en = 1'b0; ld_addr = 3'd0; ld_data = 8'h00;
        flag_we = 1'b0; Z_in = 1'b0; N_in = 1'b0;

        // Reset state
        #2;
        rd_addr_a = 3'd3; rd_addr_b = 3'd7;
        #1;
        check8("rst_out_A", out_A, 8'h00);
        check8("rst_out_B", out_B, 8'h00);
        check1("rst_Z_q", Z_q, 1'b0);
        check1("rst_N_q", N_q, 1'b0);
        step();
        step();
        rst = 1'b1;

        // Basic write/read
        do_ld(3'd1, 8'h0C);
        do_ld(3'd2, 8'h09);
        idle();
        rd_addr_a = 3'd1; rd_addr_b = 3'd2;
        #1;
        check8("basic_r1", out_A, 8'h0C);
        check8("basic_r2", out_B, 8'h09);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h15;
        step();
        idle();
        rd_addr_a = 3'd3;
        #1;
        check8("basic_r3", out_A, 8'h15);

        // r0 hardwire
        ld_en = 1'b1; ld_addr = 3'd0; ld_data = 8'hAA;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h55;
        rd_addr_a = 3'd0;
        #1;
        check8("r0_same_cycle", out_A, 8'h00);
        step();
        idle();
        #1;
        check8("r0_after_edge", out_A, 8'h00);

        // Bypass and load/write conflict
        do_ld(3'd4, 8'h01);
        idle();
        rd_addr_a = 3'd4; rd_addr_b = 3'd4;
        #1;
        check8("r4_init", out_A, 8'h01);
        ld_en = 1'b1; ld_addr = 3'd4; ld_data = 8'h7E;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h33;
        #1;
        check8("conflict_A", out_A, 8'h7E);
        check8("conflict_B", out_B, 8'h7E);
        step();
        idle();
        #1;
        check8("conflict_stored", out_A, 8'h7E);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h33;
        #1;
        check8("wr_bypass", out_A, 8'h33);
        step();
        idle();
        #1;
        check8("wr_stored", out_B, 8'h33);

        // Dual commit
        ld_en = 1'b1; ld_addr = 3'd5; ld_data = 8'h10;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h20;
        rd_addr_a = 3'd5; rd_addr_b = 3'd6;
        step();
        idle();
        #1;
        check8("dual_r5", out_A, 8'h10);
        check8("dual_r6", out_B, 8'h20);

        // Flags
        Z_in = 1'b1; N_in = 1'b0; flag_we = 1'b1;
        step();
        flag_we = 1'b0; Z_in = 1'b0; N_in = 1'b1;
        #1;
        check1("flag_Z_set", Z_q, 1'b1);
        check1("flag_N_clr", N_q, 1'b0);
        step();
        check1("flag_Z_hold", Z_q, 1'b1);
        check1("flag_N_hold", N_q, 1'b0);

        // Reset clear: fill r1..r7, then pulse reset between edges
        for (int i = 1; i < 8; i++) do_ld(3'(i), 8'hFF);
        idle();
        rd_addr_a = 3'd7; rd_addr_b = 3'd1;
        #1;
        check8("fill_r7", out_A, 8'hFF);
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 8'h77;
        flag_we = 1'b1; Z_in = 1'b1; N_in = 1'b1;
        rst = 1'b0;
        #1;
        check1("midrst_Z_q", Z_q, 1'b0);
        check1("midrst_N_q", N_q, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(i + 4);
            #1;
            check8("midrst_A", out_A, 8'h00);
            check8("midrst_B", out_B, 8'h00);
        end
        step();
        idle();
        Z_in = 1'b0; N_in = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(i + 4);
            #1;
            check8("postrst_A", out_A, 8'h00);
            check8("postrst_B", out_B, 8'h00);
        end
        check1("postrst_Z_q", Z_q, 1'b0);

        // First write after release is accepted
        step();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hA5;
        rd_addr_a = 3'd2; rd_addr_b = 3'd2;
        step();
        idle();
        #1;
        check8("first_wr", out_A, 8'hA5);

        // A few mixed cycles for the per-cycle model compare
        for (int i = 0; i < 20; i++) begin
            ld_en = i[0]; ld_addr = 3'(i * 3); ld_data = 8'(i * 37 + 5);
            wr_en = i[1]; wr_addr = 3'(i * 5 + 1); wr_data = 8'(i * 91 + 3);
            rd_addr_a = 3'(i); rd_addr_b = 3'(i * 3);
            flag_we = i[2]; Z_in = i[0]; N_in = i[3];
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
